// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer: mode encodings and
// the stall counter width.
package mux_pkg;

  typedef enum logic {
    MODE_EXPLICIT = 1'b0,
    MODE_RR       = 1'b1
  } mux_mode_e;

  localparam int MUX_STALL_W = 16;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found after ptr,
// wrapping around, wins. The pointer register belongs to the caller.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  int              idx;
  logic [SEL_W-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    idx          = 0;
    cand         = '0;
    // ptr is always a legal index, so one subtraction is enough to wrap.
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      cand = SEL_W'(idx);
      if (!any_grant && req[cand]) begin
        any_grant          = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mux_nto1_reg.sv
// Registered N:1 multiplexer with valid/ready on every port, explicit-select or
// round-robin mode. Define MUX_STALL_CNT_EN to add the saturating stall_cnt output.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
`ifdef MUX_STALL_CNT_EN
  , output logic [MUX_STALL_W-1:0] stall_cnt
`endif
);

  logic [WIDTH-1:0]  in_words [NUM_IN];
  logic [NUM_IN-1:0] exp_grant;
  logic [NUM_IN-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  win_idx;
  logic              any_grant;
  logic              mode_rr;
  logic              load;
  logic              xfer;

  logic [WIDTH-1:0]  out_data_q;
  logic              out_valid_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic [SEL_W-1:0]  ptr_q;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign in_words[gi]  = in_data[gi*WIDTH +: WIDTH];
    // An out-of-range sel matches no lane, so nothing is granted.
    assign exp_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req          (in_valid),
    .ptr          (ptr_q),
    .grant_onehot (rr_grant),
    .grant_idx    (rr_idx),
    .any_grant    (rr_any)
  );

  assign mode_rr   = (mode == MODE_RR);
  assign grant     = mode_rr ? rr_grant : exp_grant;
  assign win_idx   = mode_rr ? rr_idx : sel;
  assign any_grant = mode_rr ? rr_any : (|exp_grant);

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && !Reset) ? grant : '0;
  assign xfer     = load && any_grant && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else if (load) begin
      if (xfer) begin
        out_data_q  <= in_words[win_idx];
        out_sel_q   <= win_idx;
        out_valid_q <= 1'b1;
        if (mode_rr) begin
          ptr_q <= win_idx;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_STALL_CNT_EN
  logic [MUX_STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : mux_nto1_reg

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: a 4-input instance for reset, round-robin,
// explicit select, backpressure and mid-transfer reset; a 3-input one for bad selects.
module tb_mux_nto1_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-input instance
  logic [127:0] d4_in_data;
  logic [3:0]   d4_in_valid;
  logic [3:0]   d4_in_ready;
  logic         d4_mode;
  logic [1:0]   d4_sel;
  logic [31:0]  d4_out_data;
  logic         d4_out_valid;
  logic         d4_out_ready;
  logic [1:0]   d4_out_sel;

  // 3-input instance
  logic [95:0]  d3_in_data;
  logic [2:0]   d3_in_valid;
  logic [2:0]   d3_in_ready;
  logic         d3_mode;
  logic [1:0]   d3_sel;
  logic [31:0]  d3_out_data;
  logic         d3_out_valid;
  logic         d3_out_ready;
  logic [1:0]   d3_out_sel;

`ifdef MUX_STALL_CNT_EN
  logic [15:0]  d4_stall_cnt;
  logic [15:0]  d3_stall_cnt;
`endif

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .Clk       (clk),
    .Reset     (rst),
    .in_data   (d4_in_data),
    .in_valid  (d4_in_valid),
    .in_ready  (d4_in_ready),
    .mode      (d4_mode),
    .sel       (d4_sel),
    .out_data  (d4_out_data),
    .out_valid (d4_out_valid),
    .out_ready (d4_out_ready),
    .out_sel   (d4_out_sel)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt (d4_stall_cnt)
`endif
  );

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .Clk       (clk),
    .Reset     (rst),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .mode      (d3_mode),
    .sel       (d3_sel),
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .out_sel   (d3_out_sel)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt (d3_stall_cnt)
`endif
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq_odd [4] = '{1, 3, 1, 3};

  initial begin
    rst          = 1'b1;
    d4_mode      = 1'b1;
    d4_sel       = 2'd0;
    d4_in_valid  = 4'b1111;
    d4_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d4_in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    d3_mode      = 1'b0;
    d3_sel       = 2'd0;
    d3_in_valid  = 3'b000;
    d3_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) d3_in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);

    // Two reset cycles with every input valid
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst_in_ready", 64'(d4_in_ready), 64'h0);
      check("rst3_in_ready", 64'(d3_in_ready), 64'h0);
      step();
      check("rst_out_valid", 64'(d4_out_valid), 64'h0);
      check("rst_out_data", 64'(d4_out_data), 64'h0);
      check("rst_out_sel", 64'(d4_out_sel), 64'h0);
    end
`ifdef MUX_STALL_CNT_EN
    check("rst_stall_cnt", 64'(d4_stall_cnt), 64'h0);
`endif

    // Round-robin, all valid: 0,1,2,3,0,1,2,3
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      check("rr_all_in_ready", 64'(d4_in_ready), 64'(4'b0001 << seq_all[n]));
      step();
      check("rr_all_out_sel", 64'(d4_out_sel), 64'(seq_all[n]));
      check("rr_all_out_data", 64'(d4_out_data), 64'(32'hA000_0000 + 32'(seq_all[n])));
      check("rr_all_out_valid", 64'(d4_out_valid), 64'h1);
    end

    // Round-robin, inputs 1 and 3 only: 1,3,1,3
    d4_in_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("rr_odd_in_ready", 64'(d4_in_ready), 64'(4'b0001 << seq_odd[n]));
      step();
      check("rr_odd_out_sel", 64'(d4_out_sel), 64'(seq_odd[n]));
    end

    // Explicit select of input 2
    d4_mode     = 1'b0;
    d4_sel      = 2'd2;
    d4_in_valid = 4'b1111;
    d4_in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("exp_in_ready", 64'(d4_in_ready), 64'h4);
    step();
    check("exp_out_data", 64'(d4_out_data), 64'hDEAD_BEEF);
    check("exp_out_sel", 64'(d4_out_sel), 64'h2);
    check("exp_out_valid", 64'(d4_out_valid), 64'h1);

    // Backpressure for 5 cycles while another input is selected
    d4_out_ready = 1'b0;
    d4_sel       = 2'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", 64'(d4_in_ready), 64'h0);
      step();
      check("bp_out_data", 64'(d4_out_data), 64'hDEAD_BEEF);
      check("bp_out_sel", 64'(d4_out_sel), 64'h2);
      check("bp_out_valid", 64'(d4_out_valid), 64'h1);
    end
`ifdef MUX_STALL_CNT_EN
    check("bp_stall_cnt", 64'(d4_stall_cnt), 64'd5);
`endif

    // Releasing backpressure loads the next word in the same cycle
    d4_out_ready = 1'b1;
    #1;
    check("drain_in_ready", 64'(d4_in_ready), 64'h2);
    step();
    check("drain_out_data", 64'(d4_out_data), 64'hA000_0001);
    check("drain_out_sel", 64'(d4_out_sel), 64'h1);
    check("drain_out_valid", 64'(d4_out_valid), 64'h1);
`ifdef MUX_STALL_CNT_EN
    check("drain_stall_cnt", 64'(d4_stall_cnt), 64'd5);
`endif

    // Back to round-robin: pointer kept at 3 from the last RR grant
    d4_mode = 1'b1;
    #1;
    check("rr_resume_in_ready", 64'(d4_in_ready), 64'h1);
    step();
    check("rr_resume_out_data", 64'(d4_out_data), 64'hA000_0000);

    // Explicit select of an invalid input: bubble, data held
    d4_mode     = 1'b0;
    d4_sel      = 2'd0;
    d4_in_valid = 4'b1110;
    #1;
    check("nogrant_in_ready", 64'(d4_in_ready), 64'h0);
    step();
    check("nogrant_out_valid", 64'(d4_out_valid), 64'h0);
    check("nogrant_out_data", 64'(d4_out_data), 64'hA000_0000);

    // Reset while a word is held under backpressure
    d4_sel      = 2'd2;
    d4_in_valid = 4'b1111;
    step();
    check("pre_rst_out_valid", 64'(d4_out_valid), 64'h1);
    d4_out_ready = 1'b0;
    rst          = 1'b1;
    #1;
    check("midrst_in_ready", 64'(d4_in_ready), 64'h0);
    step();
    check("midrst_out_valid", 64'(d4_out_valid), 64'h0);
    check("midrst_out_data", 64'(d4_out_data), 64'h0);
    rst          = 1'b0;
    d4_mode      = 1'b1;
    d4_out_ready = 1'b1;
    #1;
    check("post_rst_rr_in_ready", 64'(d4_in_ready), 64'h1);
    step();
    check("post_rst_rr_out_sel", 64'(d4_out_sel), 64'h0);

    // 3-input instance: legal select, then sel=3 with the word pending
    d3_sel      = 2'd1;
    d3_in_valid = 3'b111;
    #1;
    check("n3_in_ready", 64'(d3_in_ready), 64'h2);
    step();
    check("n3_out_data", 64'(d3_out_data), 64'hB000_0001);
    check("n3_out_valid", 64'(d3_out_valid), 64'h1);
    d3_sel       = 2'd3;
    d3_out_ready = 1'b0;
    #1;
    check("n3_oor_in_ready_bp", 64'(d3_in_ready), 64'h0);
    step();
    check("n3_oor_held_valid", 64'(d3_out_valid), 64'h1);
    d3_out_ready = 1'b1;
    #1;
    check("n3_oor_in_ready", 64'(d3_in_ready), 64'h0);
    step();
    check("n3_oor_out_valid", 64'(d3_out_valid), 64'h0);
    check("n3_oor_out_data", 64'(d3_out_data), 64'hB000_0001);
    check("n3_oor_out_sel", 64'(d3_out_sel), 64'h1);
`ifdef MUX_STALL_CNT_EN
    check("n3_stall_cnt", 64'(d3_stall_cnt), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_mux_nto1_reg

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised, registered N-input, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the fixed 2-bit 2:1 combinational muxes in the datapath.
- Supports two modes:
  - explicit-select mode: datapath select, as in today's muxes.
  - round-robin arbitration mode: merges requesters such as memory or writeback sources.
- Sits between producer stages and a single consumer.
- Every select value produces a defined result; there is no latched or held-over output on an unused select code.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of inputs (2..16).
- SEL_W, $clog2(NUM_IN), width of sel and out_sel (derived; do not override).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready (combinational).
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  chosen input in explicit mode; ignored in round-robin mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SEL_W  registered index of the input that produced out_data.

Behaviour:
- Reset (synchronous; Reset is sampled at the Clk edge):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer=NUM_IN-1 (so input 0 wins first).
  - While Reset is high, in_ready=0.
  - Reset mid-transfer discards the held word.
- Load enable: load = !out_valid || out_ready. The output is a single register stage; the next word may enter in the same cycle the current word drains.
- Grant, explicit mode:
  - grant = onehot(sel) & in_valid.
  - If sel >= NUM_IN, there is no grant and nothing loads.
- Grant, round-robin mode:
  - Search in_valid starting at (ptr+1) mod NUM_IN, wrapping around.
  - The first valid input wins.
- Handshake:
  - in_ready[i] = load && grant[i] && !Reset.
  - A transfer occurs on input i when in_valid[i] && in_ready[i].
- On a transfer:
  - out_data <= in_data[winner], out_sel <= winner, out_valid <= 1.
  - In round-robin mode only, ptr <= winner.
- If load is high but there is no grant: out_valid <= 0 and out_data/out_sel hold their values.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle while out_ready stays high.
- Backpressure: while out_valid && !out_ready, out_data and out_sel are stable and all in_ready are 0.
- Mode change:
  - Takes effect on the next grant evaluation.
  - ptr is kept across mode changes (it is not reset).
- Round-robin fairness: with all inputs continuously valid and out_ready=1, the grant order is 0,1,...,NUM_IN-1,0,...
- Not starvation-free in explicit mode (by definition).

Optional Feature:
- Macro: MUX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - It increments on each cycle with out_valid && !out_ready.
  - It saturates at 16'hFFFF.
  - It clears on Reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - mode encodings MODE_EXPLICIT=1'b0, MODE_RR=1'b1.
  - constant MUX_STALL_W=16.
- Sub-module rr_arbiter:
  - Parametrised by NUM_IN.
  - Inputs: req, ptr. Outputs: grant_onehot, grant_idx, any_grant.
  - Purely combinational; the ptr register lives in mux_nto1_reg.

Test Plan:
- Reset: assert Reset for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout. First RR grant after release goes to input 0.
- Explicit select: NUM_IN=4, mode=0, sel=2, in_data[2]=32'hDEADBEEF, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=32'hDEADBEEF, out_sel=2, out_valid=1.
- Out-of-range select: NUM_IN=3, SEL_W=2, sel=3, all valid -> in_ready=0, out_valid falls to 0 after the pending word drains. out_data holds its last value.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 -> sequence 1,3,1,3.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, in_ready=0. With MUX_STALL_CNT_EN, stall_cnt=5. Raising out_ready with a valid input loads the next word the same cycle, with no bubble.
- Reset mid-operation: Reset while out_valid=1 && out_ready=0 -> next cycle out_valid=0. No transfer is reported on any input during the reset cycle.
